// File: rtl/udc_pkg.sv
// udc_pkg: shared constants and types for the up/down counter and its prescaler
package udc_pkg;
  localparam int DEF_FAST_DIV = 5_000_000;
  localparam int DEF_SLOW_DIV = 25_000_000;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running two-rate divider producing a one-cycle tick
//   CLOCK_50 in  : clock
//   RST_N    in  : asynchronous active-low reset
//   fast     in  : 1 = FAST_DIV cycles per tick, 0 = SLOW_DIV
//   tick     out : one-cycle pulse every selected number of cycles
module tick_prescaler
  import udc_pkg::*;
#(
  parameter int FAST_DIV = DEF_FAST_DIV,
  parameter int SLOW_DIV = DEF_SLOW_DIV,
  parameter int DIV_W    = 26
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic fast,
  output logic tick
);
  logic [DIV_W-1:0] div_cnt, last;
  // >= rather than == so a switch to the shorter period never stalls for a full counter wrap
  always_comb begin
    last = fast ? DIV_W'(FAST_DIV - 1) : DIV_W'(SLOW_DIV - 1);
    tick = div_cnt >= last;
  end
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
endmodule

// File: rtl/updown_counter_gen.sv
// updown_counter_gen: parametrised up/down counter with wrap/saturate, load, single-step and two-rate tick
//   CLOCK_50, RST_N : clock, asynchronous active-low reset
//   run, dir_up, fast, sat, step, load, load_val : controls (step is edge-detected)
//   count, tc, at_max, at_min : count value, wrap pulse, boundary flags
//   Define UDC_SYNC_INPUTS_EN to pass the control inputs through two-flop synchronisers.
module updown_counter_gen
  import udc_pkg::*;
#(
  parameter int               WIDTH    = 18,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               FAST_DIV = DEF_FAST_DIV,
  parameter int               SLOW_DIV = DEF_SLOW_DIV,
  parameter int               DIV_W    = 26
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             run,
  input  logic             dir_up,
  input  logic             fast,
  input  logic             sat,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);
  logic run_i, dir_i, fast_i, sat_i, step_i, load_i;
`ifdef UDC_SYNC_INPUTS_EN
  logic [5:0] sync1, sync2;
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {run, dir_up, fast, sat, step, load};
      sync2 <= sync1;
    end
  assign {run_i, dir_i, fast_i, sat_i, step_i, load_i} = sync2;
`else
  assign {run_i, dir_i, fast_i, sat_i, step_i, load_i} = {run, dir_up, fast, sat, step, load};
`endif
  logic tick, step_q, adv, wrap;
  logic [WIDTH-1:0] nxt;
  dir_t dir;
  tick_prescaler #(.FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV), .DIV_W(DIV_W)) u_pre (
    .CLOCK_50(CLOCK_50),
    .RST_N(RST_N),
    .fast(fast_i),
    .tick(tick)
  );
  // bounds are compared explicitly so a non-power-of-two MAX_VAL wraps correctly
  always_comb begin
    dir    = dir_t'(dir_i);
    at_max = count == MAX_VAL;
    at_min = count == '0;
    adv    = (run_i & tick) | (step_i & ~step_q);
    wrap   = adv & ~sat_i & (dir == DIR_UP ? at_max : at_min);
    nxt    = dir == DIR_UP ? (at_max ? (sat_i ? MAX_VAL : '0) : count + 1'b1)
                           : (at_min ? (sat_i ? '0 : MAX_VAL) : count - 1'b1);
  end
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) begin
      count  <= '0;
      tc     <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= step_i;
      tc     <= wrap & ~load_i;
      if (load_i)   count <= load_val > MAX_VAL ? MAX_VAL : load_val;
      else if (adv) count <= nxt;
    end
endmodule
